red_sat_unit: RTL and testbench
===============================

RED_SAT_UNIT -- requirements
Module: red_sat_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed at 16 bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port op  input  1  0 = RED (byte reduction), 1 = SADD (16-bit saturating add).
REQ-006 SHALL have port a  input  16  operand A (rs), captured with start.
REQ-007 SHALL have port b  input  16  operand B (rt), captured with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (states EX1-EX3).
REQ-009 SHALL have port done  output  1  one-cycle pulse, result and flags valid.
REQ-010 SHALL have port result  output  16  registered result; held until next completion.
REQ-011 SHALL have port flags  output  3  registered {N,Z,V}; held until next completion.

Function
REQ-012 SHALL implement FSM states IDLE, EX1, EX2, EX3, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, latch a, b, op and enter EX1; otherwise DONE returns to IDLE.
REQ-014 SHALL ignore start while busy; latched operands SHALL not change mid-operation.
REQ-015 SHALL use one shared 16-bit adder for all additions; at most one addition per cycle.
REQ-016 SADD: EX1 computes a+b; on signed overflow, result saturates to 0x7FFF when both operands are positive and to 0x8000 when both are negative; SHALL set V=1 on saturation; carry-out ignored; EX1 -> DONE.
REQ-017 RED: EX1 computes sext(a[15:8])+sext(b[15:8]); EX2 computes sext(a[7:0])+sext(b[7:0]); EX3 adds both partials; result = 16-bit sign-extended sum (range -512..508), never saturates, V=0; EX3 -> DONE.
REQ-018 Latency from start-sample edge to done: SADD 2 cycles, RED 4 cycles.
REQ-019 result and flags SHALL update only on the edge entering DONE; Z = (result==0), N = result[15].
REQ-020 done SHALL be high exactly in DONE; busy SHALL be low in IDLE and DONE.
REQ-021 Start sampled in DONE SHALL run back-to-back with no idle cycle; done still pulses for the finishing operation.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, result=0x0000, flags=3'b000, busy=0, done=0, and clear partial-sum and operand registers.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL be handled normally.

Structure
REQ-024 Op encodings (RED, SADD) and state encodings SHALL reside in shared package red_sat_pkg.
REQ-025 Addition SHALL be performed by one instance of the team's 16-bit carry-lookahead adder (CLA_16bit); saturation and flag logic SHALL be in this module.
REQ-026 No other sub-modules; partial sums held in two 16-bit registers.

Verification
REQ-027 SADD a=0x7FFF b=0x0001 -> result 0x7FFF, flags N=0 Z=0 V=1, done 2 cycles after start.
REQ-028 SADD a=0x8000 b=0xFFFF -> 0x8000, N=1 V=1; SADD a=0x1234 b=0xEDCC -> 0x0000, Z=1 V=0.
REQ-029 RED a=0x7F7F b=0x7F7F -> 0x01FC, V=0, done 4 cycles after start; RED a=0x8080 b=0x8080 -> 0xFE00, N=1.
REQ-030 start pulsed during EX2 of a RED -> ignored; single done; result matches the original operands.
REQ-031 rst_n low during EX2 -> outputs zero immediately, no done; new SADD after release completes in 2 cycles.
REQ-032 start held across DONE (RED then SADD) -> two done pulses with no idle cycle between operations; each result correct.

Source files
------------

// File: rtl/red_sat_pkg.sv
// Shared encodings for the byte-reduction / saturating-add unit.
package red_sat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EX1  = 3'd1,
        ST_EX2  = 3'd2,
        ST_EX3  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        OP_RED  = 1'b0,
        OP_SADD = 1'b1
    } op_e;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    function automatic logic [15:0] sext8(input logic [7:0] x);
        return {{8{x[7]}}, x};
    endfunction

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit two-level carry-lookahead adder (4-bit groups). Carry-out is not
// produced because no user of this adder needs it.
module CLA_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o
);

    logic [14:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  pg;
    logic [3:0]  cg;

    always_comb begin
        g  = a_i[14:0] & b_i[14:0];
        p  = a_i ^ b_i;
        gg = '0;
        pg = '0;
        for (int k = 0; k < 3; k++) begin
            pg[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (&p[4*k+2 +: 2] & g[4*k+1])
                  | (&p[4*k+1 +: 3] & g[4*k]);
        end

        // group carries resolved in parallel from the group g/p terms
        cg[0] = cin_i;
        cg[1] = gg[0] | (pg[0] & cin_i);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin_i);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin_i);

        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (&p[4*k+1 +: 2] & g[4*k]) | (&p[4*k +: 3] & cg[k]);
        end
        sum_o = p ^ c;
    end

endmodule

// File: rtl/red_sat_unit.sv
// Multi-cycle unit: signed byte reduction (RED) or 16-bit saturating add (SADD)
// on one shared adder.  States: IDLE | wait | EX1 | SADD add or RED high bytes |
// EX2 | RED low bytes | EX3 | RED partial sum | DONE | result valid, done pulse
module red_sat_unit
    import red_sat_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [2:0]  flags
);

    state_e      state_q;
    op_e         op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] p_hi_q;
    logic [15:0] p_lo_q;
    logic [15:0] result_q;
    logic [2:0]  flags_q;
    logic        busy_q;
    logic        done_q;

    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] sum;
    logic        ovf;
    logic [15:0] sadd_res;

    always_comb begin
        add_a = a_q;
        add_b = b_q;
        case (state_q)
            ST_EX1: begin
                if (op_q == OP_RED) begin
                    add_a = sext8(a_q[15:8]);
                    add_b = sext8(b_q[15:8]);
                end
            end
            ST_EX2: begin
                add_a = sext8(a_q[7:0]);
                add_b = sext8(b_q[7:0]);
            end
            ST_EX3: begin
                add_a = p_hi_q;
                add_b = p_lo_q;
            end
            default: ;
        endcase
    end

    CLA_16bit u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (1'b0),
        .sum_o (sum)
    );

    // signed overflow only possible when operand signs agree
    always_comb begin
        ovf      = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
        sadd_res = ovf ? (a_q[15] ? SAT_NEG : SAT_POS) : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_RED;
            a_q      <= '0;
            b_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op_e'(op);
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= ST_EX1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_EX1: begin
                    if (op_q == OP_SADD) begin
                        result_q <= sadd_res;
                        flags_q  <= {sadd_res[15], sadd_res == 16'h0000, ovf};
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        p_hi_q  <= sum;
                        state_q <= ST_EX2;
                    end
                end
                ST_EX2: begin
                    p_lo_q  <= sum;
                    state_q <= ST_EX3;
                end
                ST_EX3: begin
                    result_q <= sum;
                    flags_q  <= {sum[15], sum == 16'h0000, 1'b0};
                    state_q  <= ST_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_red_sat_unit.sv
// Directed bench for red_sat_unit: vector table plus hand-written sequences for
// start-while-busy, reset mid-operation and back-to-back starts.
module tb_red_sat_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    red_sat_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic [2:0]  exp_flags;   // {N,Z,V}
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency counts the cycle whose closing edge samples start as cycle 1.
    // Operand inputs are scrambled after the sample edge to prove they are latched.
    task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] held;

        vecs[0]  = '{1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001, 2};
        vecs[1]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 3'b101, 2};
        vecs[2]  = '{1'b1, 16'h1234, 16'hEDCC, 16'h0000, 3'b010, 2};
        vecs[3]  = '{1'b1, 16'h0003, 16'h0004, 16'h0007, 3'b000, 2};
        vecs[4]  = '{1'b1, 16'h8000, 16'h8000, 16'h8000, 3'b101, 2};
        vecs[5]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3'b100, 2};
        vecs[6]  = '{1'b1, 16'h7FFF, 16'h8000, 16'hFFFF, 3'b100, 2};
        vecs[7]  = '{1'b0, 16'h7F7F, 16'h7F7F, 16'h01FC, 3'b000, 4};
        vecs[8]  = '{1'b0, 16'h8080, 16'h8080, 16'hFE00, 3'b100, 4};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b010, 4};
        vecs[10] = '{1'b0, 16'h01FF, 16'h0201, 16'h0003, 3'b000, 4};
        vecs[11] = '{1'b0, 16'hFF01, 16'h01FF, 16'h0000, 3'b010, 4};
        vecs[12] = '{1'b0, 16'h8000, 16'h0000, 16'hFF80, 3'b100, 4};

        // reset state
        #12;
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_flags", {29'h0, flags}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_result", i), {16'h0, result}, {16'h0, vecs[i].exp_res});
            check($sformatf("vec%0d_flags", i), {29'h0, flags}, {29'h0, vecs[i].exp_flags});
            check($sformatf("vec%0d_busy_in_done", i), {31'h0, busy}, 32'h0);
        end

        // result held after done, done is a single pulse
        held = result;
        @(posedge clk); #1;
        check("done_one_cycle", {31'h0, done}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("result_held", {16'h0, result}, {16'h0, held});

        // start during EX2 of a RED is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h7F7F; b = 16'h7F7F;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 16'h0101; b = 16'h0101;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) begin
                ndone++;
                check("busy_start_result", {16'h0, result}, 32'h01FC);
            end
            @(posedge clk); #1;
        end
        check("busy_start_done_count", ndone, 1);

        // reset during EX2 aborts with no done
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h7F7F; b = 16'h7F7F;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_result", {16'h0, result}, 32'h0);
        check("abort_flags", {29'h0, flags}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        ndone = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(1'b1, 16'h0003, 16'h0004, lat);
        check("post_reset_latency", lat, 2);
        check("post_reset_result", {16'h0, result}, 32'h0007);

        // start held across DONE: RED then SADD back-to-back
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h7F7F; b = 16'h7F7F;
        @(posedge clk); #1;
        op = 1'b1; a = 16'h7FFF; b = 16'h0001;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_red_latency", lat, 4);
        check("b2b_red_result", {16'h0, result}, 32'h01FC);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_no_idle_busy", {31'h0, busy}, 32'h1);
        check("b2b_gap_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        check("b2b_sadd_done", {31'h0, done}, 32'h1);
        check("b2b_sadd_result", {16'h0, result}, 32'h7FFF);
        check("b2b_sadd_flags", {29'h0, flags}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
